// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants: FSM encoding, NOP word, reset vector.
package riscv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPCODE_W = 7;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_stage_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold, otherwise the slot empties.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic            hold_i,
  input  fetch_pkt_t      pkt_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pkt_i.pc;
      instr_q <= pkt_i.instr;
    end else if (!hold_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Single-outstanding instruction fetch with redirect flush and a one-entry
// skid buffer for responses that land while decode is stalled.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  fetch_stage_if.master       imem,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                id_valid,
  output logic [XLEN-1:0]     id_pc,
  output logic [XLEN-1:0]     id_instr,
  output logic [OPCODE_W-1:0] id_opcode
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pending_pc_q, pending_pc_d;
  logic            drop_q, drop_d;
  fetch_pkt_t      buf_q, buf_d;

  logic            req_valid_c;
  logic            load_c;
  fetch_pkt_t      load_pkt_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH_REQ;
      pc_q         <= RESET_PC;
      pending_pc_q <= '0;
      drop_q       <= 1'b0;
      buf_q        <= '{pc: '0, instr: NOP_INSTR};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      drop_q       <= drop_d;
      buf_q        <= buf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    drop_d       = drop_q;
    buf_d        = buf_q;
    req_valid_c  = 1'b0;
    load_c       = 1'b0;
    load_pkt_c   = buf_q;

    case (state_q)
      FETCH_REQ: begin
        // A redirect cycle never issues, so the request always carries the new target.
        req_valid_c = !redirect_valid;
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (imem.imem_req_ready) begin
          pending_pc_d = pc_q;
          pc_d         = pc_q + 32'd4;
          state_d      = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem.imem_rsp_valid) begin
          state_d = FETCH_REQ;
          if (drop_q || redirect_valid) begin
            drop_d = 1'b0;
            if (redirect_valid) pc_d = redirect_pc;
          end else if (!stall || !id_valid) begin
            load_c     = 1'b1;
            load_pkt_c = '{pc: pending_pc_q, instr: imem.imem_rsp_data};
          end else begin
            buf_d   = '{pc: pending_pc_q, instr: imem.imem_rsp_data};
            state_d = FETCH_HOLD;
          end
        end else if (redirect_valid) begin
          // Response still owed by memory; mark it stale instead of abandoning it.
          pc_d   = redirect_pc;
          drop_d = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = FETCH_REQ;
        end else if (!stall) begin
          load_c  = 1'b1;
          state_d = FETCH_REQ;
        end
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  assign imem.imem_req_valid = req_valid_c && !rst;
  assign imem.imem_addr      = pc_q;

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_c),
    .flush_i (redirect_valid),
    .hold_i  (stall),
    .pkt_i   (load_pkt_c),
    .valid_o (id_valid),
    .pc_o    (id_pc),
    .instr_o (id_instr)
  );

  assign id_opcode = id_instr[OPCODE_W-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Fetch-stage bench: randomized memory and control, program-order scoreboard
// checked by an independent monitor, plus directed corner scenarios.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (bus),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_opcode      (id_opcode)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image: word 0 is addi x1,x0,5; everything else is an address hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B9) ^ {a[15:0], a[31:16]};
  endfunction

  // ---------------- memory model ----------------
  int unsigned ready_pct = 100;
  int unsigned lat_min   = 1;
  int unsigned lat_max   = 1;
  int unsigned spur_pct  = 0;
  bit          m_pend;
  int unsigned m_cnt;
  logic [31:0] m_addr;
  bit          m_fire;
  logic [31:0] m_faddr;

  initial begin
    m_pend = 1'b0;
    m_cnt  = 0;
    m_addr = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      m_fire  = bus.imem_req_valid && bus.imem_req_ready;
      m_faddr = bus.imem_addr;
      @(posedge clk);
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (m_fire) begin
        m_pend = 1'b1;
        m_addr = m_faddr;
        m_cnt  = $urandom_range(lat_max, lat_min);
      end
      if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_word(m_addr);
          m_pend = 1'b0;
        end
      end else if ($urandom_range(99, 0) < spur_pct) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = $urandom;
      end
      bus.imem_req_ready = !m_pend && ($urandom_range(99, 0) < ready_pct);
    end
  end

  // ---------------- scoreboard monitor ----------------
  // Program-order model: after reset or redirect to X, the next instructions
  // reaching decode must be X, X+4, X+8, ... each carrying mem_word(pc).
  logic [31:0] exp_q[$];
  bit          p_rst = 1'b1, p_red = 1'b0, p_stall = 1'b0, p_idv = 1'b0;
  logic [31:0] p_pc = '0, p_instr = '0;
  int          idle = 0;
  int          delivered = 0;

  initial begin
    logic [31:0] e;
    logic [31:0] w;
    exp_q.push_back(RST_PC);
    forever begin
      @(negedge clk);
      if (rst) begin
        check("req_valid_during_rst", 32'(bus.imem_req_valid), 32'd0);
        exp_q.delete();
        exp_q.push_back(RST_PC);
        idle = 0;
      end else begin
        if (p_rst) begin
          check("id_valid_after_rst", 32'(id_valid), 32'd0);
          check("addr_after_rst", bus.imem_addr, RST_PC);
        end else if (p_red) begin
          check("id_valid_after_redirect", 32'(id_valid), 32'd0);
        end else if (p_stall && p_idv) begin
          check("hold_valid", 32'(id_valid), 32'd1);
          check("hold_pc", id_pc, p_pc);
          check("hold_instr", id_instr, p_instr);
        end else if (id_valid) begin
          e = exp_q.pop_front();
          exp_q.push_back(e + 32'd4);
          w = mem_word(e);
          check("sb_id_pc", id_pc, e);
          check("sb_id_instr", id_instr, w);
          check("sb_id_opcode", 32'(id_opcode), 32'(w[6:0]));
          delivered++;
          idle = 0;
        end
        if (redirect_valid) begin
          exp_q.delete();
          exp_q.push_back(redirect_pc);
        end
        idle++;
        if (idle > 300) begin
          n_tests++;
          n_fail++;
          $display("FAIL progress: %0d cycles without a new decode instruction, expected <= 300", idle);
          idle = 0;
        end
      end
      p_rst   = rst;
      p_red   = redirect_valid;
      p_stall = stall;
      p_idv   = id_valid;
      p_pc    = id_pc;
      p_instr = id_instr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit st, input bit rd, input logic [31:0] rpc, input bit r);
    @(posedge clk);
    #1;
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    rst            = r;
    @(negedge clk);
  endtask

  task automatic wait_valid(input bit st, output int n);
    n = 0;
    do begin
      cyc(st, 1'b0, 32'h0, 1'b0);
      n++;
    end while (!id_valid && n < 20);
  endtask

  task automatic wait_hs(output int n);
    n = 0;
    do begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      n++;
    end while (!(bus.imem_req_valid && bus.imem_req_ready) && n < 20);
  endtask

  initial begin
    int          n;
    bit          seen;
    logic [31:0] held_pc;
    int          base;
    bit          st, rd, r;
    logic [31:0] rpc;

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_instr", id_instr, 32'h0);

    // First fetch with a one-cycle memory, then back-to-back throughput.
    wait_valid(1'b0, n);
    check("first_latency", 32'(n), 32'd3);
    check("first_pc", id_pc, 32'h0);
    check("first_instr", id_instr, 32'h0050_0093);
    check("first_opcode", 32'(id_opcode), 32'h13);
    wait_valid(1'b0, n);
    check("throughput_gap", 32'(n), 32'd2);
    check("second_pc", id_pc, 32'h4);

    // Response lands under stall with a live IF/ID entry: buffered, released later.
    wait_valid(1'b1, n);
    check("stall_load_seen", 32'(id_valid), 32'd1);
    held_pc = id_pc;
    repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    check("stall_held_pc", id_pc, held_pc);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("release_cycle_pc", id_pc, held_pc);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("release_valid", 32'(id_valid), 32'd1);
    check("release_pc", id_pc, held_pc + 32'd4);
    check("release_instr", id_instr, mem_word(held_pc + 32'd4));

    // Redirect while a slow response is outstanding.
    lat_min = 3; lat_max = 3;
    wait_hs(n);
    check("hs_before_redirect", 32'(bus.imem_req_valid && bus.imem_req_ready), 32'd1);
    cyc(1'b0, 1'b1, 32'h100, 1'b0);
    seen = 1'b0;
    n = 0;
    do begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      if (id_valid) seen = 1'b1;
      n++;
    end while (!bus.imem_req_valid && n < 20);
    check("redirect_stale_dropped", 32'(seen), 32'd0);
    check("redirect_addr", bus.imem_addr, 32'h100);

    // Redirect and stall together: redirect wins.
    lat_min = 1; lat_max = 1;
    wait_valid(1'b1, n);
    check("pre_flush_valid", 32'(id_valid), 32'd1);
    cyc(1'b1, 1'b1, 32'h200, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("redirect_beats_stall", 32'(id_valid), 32'd0);

    // PC wrap at the top of the address space.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    wait_hs(n);
    check("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    wait_hs(n);
    check("wrap_addr_zero", bus.imem_addr, 32'h0);

    // Reset while waiting; the old response arrives right after reset.
    lat_min = 2; lat_max = 2;
    wait_hs(n);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_wait_addr", bus.imem_addr, RST_PC);
    check("rst_wait_id_valid", 32'(id_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_wait_ignored", 32'(id_valid), 32'd0);

    // Randomized traffic.
    ready_pct = 70; lat_min = 1; lat_max = 3; spur_pct = 10;
    base = delivered;
    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(3, 0) == 0);
      rd  = ($urandom_range(24, 0) == 0);
      r   = ($urandom_range(199, 0) == 0);
      rpc = {$urandom_range(32'h3FFF_FFFF, 0), 2'b00};
      if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFF0 | {28'h0, rpc[3:2], 2'b00};
      cyc(st, rd, rpc, r);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("random_progress", 32'((delivered - base) > 100), 32'd1);

    repeat (2) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
